// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Control sequencer for one fetch/execute pass of a register-to-register ALU
// instruction on a single-bus datapath. A start request runs these steps:
// fetch (T0..T2), operand transfer (T3), ALU operation (T4) and write-back
// (T5, and T6 for mul/div). The sequence ends with a one-cycle done pulse.
// Every strobe is a Moore decode of the registered state and the captured IR.
//
// Ports
//   clock, clear        rising-edge clock, synchronous active-high reset
//   start               request one instruction (ignored while busy)
//   mem_ready           memory read complete (stalls T1 while low)
//   ir_value            instruction word from the memory data path
//   busy/done/illegal   status: active, completion pulse, illegal pulse
//   pc_out..y_in        fetch/datapath strobes
//   zlow_*/zhigh_*/lo_in/hi_in/alu_en   Z, HI/LO and ALU strobes
//   alu_op              opcode latched for the ALU
//   gp_out / gp_in      one-hot register bus-drive / load enables
module alu_op_sequencer #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir_value,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                pc_in,
  output logic                md_read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                zlow_in,
  output logic                zhigh_in,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic                lo_in,
  output logic                hi_in,
  output logic                alu_en,
  output logic [4:0]          alu_op,
  output logic [NUM_REGS-1:0] gp_out,
  output logic [NUM_REGS-1:0] gp_in
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] ir_q;
  logic              ill_q;
  logic              t1_first;
  logic [4:0]        op_q;
  logic [3:0]        ra_q, rb_q, rc_q;
  logic              unused_ir_parity;

  function automatic logic is_binary(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
                      OP_SHR, OP_SHRA, OP_SHL, OP_MUL, OP_DIV};
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return op inside {OP_NEG, OP_NOT};
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {OP_MUL, OP_DIV};
  endfunction

  function automatic logic reg_ok(input logic [3:0] idx);
    return int'({28'd0, idx}) < NUM_REGS;
  endfunction

  // mul/div write HI/LO rather than Ra, so Ra is only checked when it is a destination.
  function automatic logic is_legal(input logic [DATA_W-1:0] w);
    logic [4:0] op;
    logic       ra_used;
    op      = w[31:27];
    ra_used = !is_muldiv(op);
    if (is_binary(op))
      return (!ra_used || reg_ok(w[26:23])) && reg_ok(w[22:19]) && reg_ok(w[18:15]);
    else if (is_unary(op))
      return reg_ok(w[26:23]) && reg_ok(w[22:19]);
    else
      return 1'b0;
  endfunction

  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == i[3:0]) v[i] = 1'b1;
    return v;
  endfunction

  assign op_q = ir_q[31:27];
  assign ra_q = ir_q[26:23];
  assign rb_q = ir_q[22:19];
  assign rc_q = ir_q[18:15];
  // Only the opcode and register fields are decoded; the rest of IR is carried along.
  assign unused_ir_parity = ^ir_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= S_IDLE;
      ir_q     <= '0;
      alu_op   <= '0;
      ill_q    <= 1'b0;
      t1_first <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_T0;
        S_T0: begin
          state    <= S_T1;
          t1_first <= 1'b1;
        end
        S_T1: begin
          t1_first <= 1'b0;
          if (mem_ready) state <= S_T2;
        end
        S_T2: begin
          // The legality decision uses the word being captured, so an illegal
          // instruction goes straight to DONE without issuing any execute strobe.
          ir_q   <= ir_value;
          alu_op <= ir_value[31:27];
          ill_q  <= !is_legal(ir_value);
          if (!is_legal(ir_value))          state <= S_DONE;
          else if (is_binary(ir_value[31:27])) state <= S_T3;
          else                              state <= S_T4;
        end
        S_T3:    state <= S_T4;
        S_T4:    state <= S_T5;
        S_T5:    state <= is_muldiv(op_q) ? S_T6 : S_DONE;
        S_T6:    state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = 1'b0;
    illegal   = 1'b0;
    pc_out    = 1'b0;
    mar_in    = 1'b0;
    inc_pc    = 1'b0;
    pc_in     = 1'b0;
    md_read   = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    zlow_in   = 1'b0;
    zhigh_in  = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    lo_in     = 1'b0;
    hi_in     = 1'b0;
    alu_en    = 1'b0;
    gp_out    = '0;
    gp_in     = '0;
    case (state)
      S_T0: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        zlow_in = 1'b1;
      end
      S_T1: begin
        // The incremented PC is loaded once; the memory strobes stay up through a stall.
        zlow_out = 1'b1;
        pc_in    = t1_first;
        md_read  = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        gp_out = reg_sel(rb_q);
        y_in   = 1'b1;
      end
      S_T4: begin
        alu_en   = 1'b1;
        zlow_in  = 1'b1;
        zhigh_in = is_muldiv(op_q);
        gp_out   = reg_sel(is_binary(op_q) ? rc_q : rb_q);
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (is_muldiv(op_q)) lo_in = 1'b1;
        else                 gp_in = reg_sel(ra_q);
      end
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = ill_q;
      end
      default: ;
    endcase
  end

endmodule
